// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI3-subset slave memory with independent write and read burst FSMs
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   AWVALID/AWREADY/AWID/AWLEN/AWADDR write address channel (word address, beats = AWLEN+1)
//   WVALID/WREADY/WLAST/WID/WDATA     write data channel
//   BVALID/BREADY/BID                 write response channel
//   ARVALID/ARREADY/ARID/ARLEN/ARADDR read address channel
//   RVALID/RREADY/RLAST/RID/RDATA     read data channel (RDATA read combinationally from the array)
//   protocol_err                      sticky flag for WLAST/WID mismatch
module axi_mem_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_WORDS_LOG2 = 16,
    parameter int READ_LATENCY   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  AWREADY,
    input  logic                  AWVALID,
    input  logic [3:0]            AWID,
    input  logic [3:0]            AWLEN,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  WREADY,
    input  logic                  WVALID,
    input  logic                  WLAST,
    input  logic [3:0]            WID,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  BREADY,
    output logic                  BVALID,
    output logic [3:0]            BID,
    output logic                  ARREADY,
    input  logic                  ARVALID,
    input  logic [3:0]            ARID,
    input  logic [3:0]            ARLEN,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  RREADY,
    output logic                  RVALID,
    output logic                  RLAST,
    output logic [3:0]            RID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  protocol_err
);
    localparam int CW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
    logic [DATA_WIDTH-1:0] r_mem [0:2**MEM_WORDS_LOG2-1];
    w_state_t              r_wstate;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [3:0]            r_wleft;
    logic                  r_awready, r_wready, r_bvalid, r_err;
    logic [3:0]            r_bid;
    r_state_t              r_rstate;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [3:0]            r_rleft;
    logic [CW-1:0]         r_rcnt;
    logic                  r_arready, r_rvalid, r_rlast;
    logic [3:0]            r_rid;
    logic                  w_wlast, w_we;
    // r_wleft holds beats remaining minus one, so zero marks the final beat
    assign w_wlast = r_wleft == 4'd0;
    // a beat arriving on a reset edge is dropped so an abandoned burst leaves no trace
    assign w_we    = !rst && r_wstate == W_DATA && WVALID;
    assign AWREADY      = r_awready;
    assign WREADY       = r_wready;
    assign BVALID       = r_bvalid;
    assign BID          = r_bid;
    assign ARREADY      = r_arready;
    assign RVALID       = r_rvalid;
    assign RLAST        = r_rlast;
    assign RID          = r_rid;
    assign protocol_err = r_err;
    assign RDATA        = r_rvalid ? r_mem[r_raddr[MEM_WORDS_LOG2-1:0]] : '0;
    always_ff @(posedge clk)
        if (w_we) r_mem[r_waddr[MEM_WORDS_LOG2-1:0]] <= WDATA;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: if (AWVALID) begin
                    r_bid     <= AWID;
                    r_waddr   <= AWADDR;
                    r_wleft   <= AWLEN;
                    r_awready <= 1'b0;
                    r_wready  <= 1'b1;
                    r_wstate  <= W_DATA;
                end
                W_DATA: if (WVALID) begin
                    r_waddr <= r_waddr + 1'b1;
                    r_wleft <= r_wleft - 1'b1;
                    if (WLAST != w_wlast || WID != r_bid) r_err <= 1'b1;
                    if (w_wlast) begin
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: if (BREADY) begin
                    r_bvalid  <= 1'b0;
                    r_awready <= 1'b1;
                    r_wstate  <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: if (ARVALID) begin
                    r_rid     <= ARID;
                    r_raddr   <= ARADDR;
                    r_rleft   <= ARLEN;
                    r_rcnt    <= CW'(READ_LATENCY - 1);
                    r_arready <= 1'b0;
                    r_rstate  <= R_WAIT;
                end
                R_WAIT: if (r_rcnt == '0) begin
                    r_rvalid <= 1'b1;
                    r_rlast  <= r_rleft == 4'd0;
                    r_rstate <= R_BURST;
                end else begin
                    r_rcnt <= r_rcnt - 1'b1;
                end
                R_BURST: if (RREADY) begin
                    if (r_rlast) begin
                        r_rvalid  <= 1'b0;
                        r_rlast   <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end else begin
                        r_raddr <= r_raddr + 1'b1;
                        r_rleft <= r_rleft - 1'b1;
                        r_rlast <= r_rleft == 4'd1;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: transaction-level model check of axi_mem_responder with directed and random traffic
module tb_axi_mem_responder;
    localparam int LOG2 = 8;
    localparam int D    = 2**LOG2;
    localparam int L    = 4;
    logic        clk = 0, rst = 0;
    logic        AWREADY, AWVALID = 0;
    logic [3:0]  AWID = 0, AWLEN = 0;
    logic [31:0] AWADDR = 0;
    logic        WREADY, WVALID = 0, WLAST = 0;
    logic [3:0]  WID = 0;
    logic [31:0] WDATA = 0;
    logic        BREADY = 0, BVALID;
    logic [3:0]  BID;
    logic        ARREADY, ARVALID = 0;
    logic [3:0]  ARID = 0, ARLEN = 0;
    logic [31:0] ARADDR = 0;
    logic        RREADY = 0, RVALID, RLAST;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic        protocol_err;
    axi_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS_LOG2(LOG2), .READ_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .AWREADY(AWREADY), .AWVALID(AWVALID), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
        .WREADY(WREADY), .WVALID(WVALID), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
        .BREADY(BREADY), .BVALID(BVALID), .BID(BID),
        .ARREADY(ARREADY), .ARVALID(ARVALID), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
        .RREADY(RREADY), .RVALID(RVALID), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
        .protocol_err(protocol_err)
    );
    always #5 clk = ~clk;
    bit [31:0] mem_m [D];
    bit        known [D];
    bit        w_busy, r_busy, err_m, post_rst;
    bit [3:0]  w_id, bid_m, rid_m;
    bit [31:0] w_addr, r_addr;
    int        w_left, r_len, r_beat, r_age;
    int        checks = 0, failures = 0;
    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [3:0]  rd_id;
    int          lat;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic compare();
        bit rv;
        int idx;
        rv  = r_busy && r_age >= L;
        idx = int'((r_addr + 32'(r_beat)) % D);
        chk("AWREADY", AWREADY, !w_busy);
        chk("WREADY", WREADY, w_busy && w_left > 0);
        chk("BVALID", BVALID, w_busy && w_left == 0);
        chk("BID", BID, bid_m);
        chk("ARREADY", ARREADY, !r_busy);
        chk("RVALID", RVALID, rv);
        chk("RLAST", RLAST, rv && r_beat == r_len);
        chk("RID", RID, rid_m);
        chk("protocol_err", protocol_err, err_m);
        if (rv && known[idx]) chk("RDATA", RDATA, mem_m[idx]);
        else if (post_rst) chk("RDATA_reset", RDATA, 0);
    endtask
    task automatic tick();
        bit aw, w, b, ar, r;
        int idx;
        if (rst) begin
            w_busy = 0; r_busy = 0; bid_m = 0; rid_m = 0; err_m = 0; post_rst = 1;
        end else begin
            post_rst = 0;
            aw = AWVALID && !w_busy;
            w  = WVALID && w_busy && w_left > 0;
            b  = BREADY && w_busy && w_left == 0;
            ar = ARVALID && !r_busy;
            r  = RREADY && r_busy && r_age >= L;
            if (w) begin
                idx = int'(w_addr % D);
                mem_m[idx] = WDATA;
                known[idx] = 1;
                if (WLAST != (w_left == 1) || WID != w_id) err_m = 1;
                w_addr++;
                w_left--;
            end
            if (b) w_busy = 0;
            if (aw) begin
                w_busy = 1; w_id = AWID; bid_m = AWID; w_addr = AWADDR; w_left = int'(AWLEN) + 1;
            end
            if (r) begin
                if (r_beat == r_len) r_busy = 0;
                else r_beat++;
            end
            if (r_busy) r_age++;
            if (ar) begin
                r_busy = 1; rid_m = ARID; r_addr = ARADDR; r_len = int'(ARLEN); r_beat = 0; r_age = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask
    task automatic write_burst(input logic [3:0] id, input logic [3:0] len, input logic [31:0] addr,
                               input logic [31:0] base, input int bad_last, input int bdelay);
        AWVALID = 1; AWID = id; AWLEN = len; AWADDR = addr;
        tick();
        AWVALID = 0;
        for (int i = 0; i <= int'(len); i++) begin
            WVALID = 1; WID = id; WDATA = base + 32'(i);
            WLAST = bad_last >= 0 ? (i == bad_last) : (i == int'(len));
            tick();
        end
        WVALID = 0; WLAST = 0;
        repeat (bdelay) tick();
        chk("bvalid_hold", BVALID, 1);
        chk("bid_hold", BID, id);
        BREADY = 1;
        tick();
        BREADY = 0;
    endtask
    task automatic read_burst(input logic [3:0] id, input logic [3:0] len, input logic [31:0] addr, input int stall_at);
        ARVALID = 1; ARID = id; ARLEN = len; ARADDR = addr;
        tick();
        ARVALID = 0;
        RREADY = 0;
        lat = 0;
        while (!RVALID && lat < 20) begin
            tick();
            lat++;
        end
        rd_id = RID;
        for (int b = 0; b <= int'(len); b++) begin
            rd_data[b] = RDATA;
            rd_last[b] = RLAST;
            if (b == stall_at) repeat (3) tick();
            RREADY = 1;
            tick();
            RREADY = 0;
        end
    endtask
    initial begin
        rst = 1;
        tick();
        chk("rst_AWREADY", AWREADY, 1);
        chk("rst_ARREADY", ARREADY, 1);
        chk("rst_WREADY", WREADY, 0);
        chk("rst_BVALID", BVALID, 0);
        chk("rst_RVALID", RVALID, 0);
        chk("rst_RLAST", RLAST, 0);
        chk("rst_BID", BID, 0);
        chk("rst_RID", RID, 0);
        chk("rst_RDATA", RDATA, 0);
        chk("rst_err", protocol_err, 0);
        rst = 0;
        write_burst(4'd3, 4'd3, 32'h10, 32'hA0, -1, 5);
        chk("wr_err_clean", protocol_err, 0);
        read_burst(4'd5, 4'd3, 32'h10, 1);
        chk("rd_latency", 32'(lat), 4);
        chk("rd_id", rd_id, 5);
        for (int i = 0; i < 4; i++) begin
            chk("rd_data", rd_data[i], 32'hA0 + 32'(i));
            chk("rd_last", rd_last[i], i == 3);
        end
        write_burst(4'd7, 4'd1, 32'(D - 1), 32'hB0, -1, 0);
        read_burst(4'd8, 4'd1, 32'(D - 1), -1);
        chk("wrap_top", rd_data[0], 32'hB0);
        chk("wrap_zero", rd_data[1], 32'hB1);
        write_burst(4'd2, 4'd2, 32'h30, 32'hC0, 0, 0);
        chk("err_set", protocol_err, 1);
        write_burst(4'd1, 4'd0, 32'h31, 32'hC8, -1, 0);
        chk("err_sticky", protocol_err, 1);
        write_burst(4'd4, 4'd7, 32'h40, 32'hD0, -1, 0);
        write_burst(4'd4, 4'd7, 32'h80, 32'hE0, -1, 0);
        AWVALID = 1; AWID = 1; AWLEN = 7; AWADDR = 32'h40;
        ARVALID = 1; ARID = 2; ARLEN = 7; ARADDR = 32'h80;
        tick();
        AWVALID = 0; ARVALID = 0;
        for (int i = 0; i < 6; i++) begin
            WVALID = i < 3; WID = 1; WLAST = 0; WDATA = 32'hF0 + 32'(i); RREADY = 1;
            tick();
        end
        chk("mid_rvalid", RVALID, 1);
        rst = 1; WVALID = 1; WDATA = 32'hF3;
        tick();
        chk("ovl_AWREADY", AWREADY, 1);
        chk("ovl_WREADY", WREADY, 0);
        chk("ovl_RVALID", RVALID, 0);
        chk("ovl_ARREADY", ARREADY, 1);
        chk("ovl_err", protocol_err, 0);
        rst = 0; WVALID = 0; RREADY = 0;
        read_burst(4'd6, 4'd7, 32'h40, -1);
        for (int i = 0; i < 8; i++)
            chk("ovl_keep", rd_data[i], i < 3 ? 32'hF0 + 32'(i) : 32'hD0 + 32'(i));
        for (int n = 0; n < 4000; n++) begin
            rst     = $urandom_range(0, 499) == 0;
            AWVALID = $urandom_range(0, 3) == 0;
            AWID    = 4'($urandom);
            AWLEN   = 4'($urandom);
            AWADDR  = $urandom;
            WVALID  = $urandom_range(0, 2) != 0;
            WDATA   = $urandom;
            WID     = $urandom_range(0, 39) == 0 ? ~w_id : w_id;
            WLAST   = (w_left == 1) ^ ($urandom_range(0, 39) == 0);
            BREADY  = $urandom_range(0, 1) == 1;
            ARVALID = $urandom_range(0, 3) == 0;
            ARID    = 4'($urandom);
            ARLEN   = 4'($urandom);
            ARADDR  = $urandom;
            RREADY  = $urandom_range(0, 3) != 0;
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
